// File: rtl/conv_result_uart_tx.sv
// Result-BRAM readout engine: walks every convolved byte in address order and
// serialises each one onto a UART 8N1 line.
module conv_result_uart_tx #(
  parameter int unsigned N            = 20,
  parameter int unsigned P            = 3,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned RD_LAT       = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        conv_done,
  output logic        ena_rd,
  output logic [13:0] addr_rd,
  input  logic [7:0]  dout_rd,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int unsigned SIDE       = N - P + 1;
  localparam int unsigned NUM_BYTES  = SIDE * SIDE;
  localparam int unsigned CNT_MAX    = (CLKS_PER_BIT > RD_LAT) ? CLKS_PER_BIT : RD_LAT;
  localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [13:0] LAST_ADDR  = 14'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // baud counter, also times the BRAM fetch
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [13:0]      addr_d;
  logic             tx_d, busy_d, ena_d, done_d;

  // Next-state, datapath and next-output logic; outputs follow the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    addr_d  = addr_rd;

    unique case (state_q)
      S_IDLE: begin
        if (start && conv_done) begin
          addr_d  = 14'd0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cnt_q == FETCH_LAST) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        shift_d = dout_rd;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BAUD_LAST) begin
          cnt_d = '0;
          if (addr_rd == LAST_ADDR) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_rd + 14'd1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ena_d  = (state_d == S_FETCH);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, datapath and registered outputs; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      addr_rd <= 14'd0;
      ena_rd  <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      addr_rd <= addr_d;
      ena_rd  <= ena_d;
      tx      <= tx_d;
      busy    <= busy_d;
      tx_done <= done_d;
    end
  end

endmodule

// File: tb/tb_conv_result_uart_tx.sv
// Bench for conv_result_uart_tx: two instances (BRAM latency 1 and 2) share the
// stimulus; a timeline model predicts every output each cycle and a UART
// decoder recovers the bytes.
module tb_conv_result_uart_tx;

  localparam int unsigned N   = 5;
  localparam int unsigned P   = 3;
  localparam int unsigned CPB = 4;
  localparam int NB = (N - P + 1) * (N - P + 1);
  localparam int EXP_BP  [2] = '{42, 43};
  localparam int EXP_TOT [2] = '{378, 387};
  localparam logic [9:0] A5_FRAME = 10'b1101001010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic conv_done = 1'b0;
  logic        tx [2];
  logic        busy [2];
  logic        tx_done [2];
  logic        ena_rd [2];
  logic [13:0] addr_rd [2];
  logic [7:0]  dout_rd [2];
  logic [7:0]  mem [NB];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // model state
  bit          m_act [2];
  int          m_c [2];
  logic [13:0] m_addr [2];
  int          acc_cyc [2];
  int          done_cyc [2];
  int          done_n [2];
  logic        hist [2][512];

  // UART decoder state
  bit         inf [2];
  int         fc [2];
  logic [7:0] sh [2];
  int         rx_n [2];
  logic [7:0] rx_b [2][64];
  int         rx_t [2][64];
  int         fr_err [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [7:0] p1;
    conv_result_uart_tx #(.N(N), .P(P), .CLKS_PER_BIT(CPB), .RD_LAT(g + 1)) dut (
      .clk(clk), .rst(rst), .start(start), .conv_done(conv_done),
      .ena_rd(ena_rd[g]), .addr_rd(addr_rd[g]), .dout_rd(dout_rd[g]),
      .tx(tx[g]), .busy(busy[g]), .tx_done(tx_done[g]));

    // BRAM read port with latency g+1
    always @(posedge clk) begin
      if (ena_rd[g]) p1 <= mem[addr_rd[g][3:0]];
      if (g == 0) begin
        if (ena_rd[g]) dout_rd[g] <= mem[addr_rd[g][3:0]];
      end else begin
        dout_rd[g] <= p1;
      end
    end
  end

  function automatic int bp(input int g);
    return g + 2 + 10 * CPB;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h want %0h at cycle %0d", nm, g, act, exp, cyc);
    end
  endtask

  // Model: tracks cycles since acceptance for each instance
  always @(posedge clk) begin
    cyc++;
    for (int g = 0; g < 2; g++) begin
      if (rst !== 1'b1) begin
        m_act[g]  = 1'b0;
        m_addr[g] = 14'd0;
      end else if (m_act[g]) begin
        m_c[g]++;
        if (m_c[g] == NB * bp(g) + 1) begin
          m_act[g]  = 1'b0;
          m_addr[g] = 14'(NB - 1);
        end
      end else if (start && conv_done) begin
        m_act[g]   = 1'b1;
        m_c[g]     = 0;
        acc_cyc[g] = cyc;
      end
    end
  end

  // Compare every output against the timeline model each cycle
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int b, o, p, rl, bpg;
      logic etx, ebusy, edone, eena;
      logic [13:0] eaddr;
      rl = g + 1;
      bpg = bp(g);
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0; eena = 1'b0; eaddr = m_addr[g];
      if (m_act[g]) begin
        if (m_c[g] < NB * bpg) begin
          b = m_c[g] / bpg;
          o = m_c[g] % bpg;
          eaddr = 14'(b);
          ebusy = 1'b1;
          eena = (o < rl);
          if (o > rl) begin
            p = (o - rl - 1) / CPB;
            if (p == 0) etx = 1'b0;
            else if (p <= 8) etx = mem[b][p - 1];
          end
        end else begin
          edone = 1'b1;
          eaddr = 14'(NB - 1);
        end
        if (m_c[g] < 512) hist[g][m_c[g]] = tx[g];
      end
      if (chk_en) begin
        chk("tx", g, 32'(tx[g]), 32'(etx));
        chk("busy", g, 32'(busy[g]), 32'(ebusy));
        chk("tx_done", g, 32'(tx_done[g]), 32'(edone));
        chk("ena_rd", g, 32'(ena_rd[g]), 32'(eena));
        chk("addr_rd", g, 32'(addr_rd[g]), 32'(eaddr));
      end
      if (tx_done[g] === 1'b1) begin
        done_n[g]++;
        done_cyc[g] = cyc;
      end
    end
  end

  // UART 8N1 decoder sampling mid-bit
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      int k;
      if (rst !== 1'b1) begin
        inf[g] = 1'b0;
      end else if (!inf[g]) begin
        if (tx[g] === 1'b0) begin
          inf[g] = 1'b1;
          fc[g] = 0;
          sh[g] = 8'd0;
          if (rx_n[g] < 64) rx_t[g][rx_n[g]] = cyc;
        end
      end else begin
        fc[g]++;
        if (fc[g] % CPB == CPB / 2) begin
          k = fc[g] / CPB;
          if (k >= 1 && k <= 8) begin
            sh[g] = {tx[g], sh[g][7:1]};
          end else if (k == 9) begin
            if (tx[g] !== 1'b1) fr_err[g]++;
            if (rx_n[g] < 64) rx_b[g][rx_n[g]] = sh[g];
            rx_n[g]++;
            inf[g] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic cd);
    start = 1'b1;
    conv_done = cd;
    tick(1);
    start = 1'b0;
  endtask

  task automatic clear_run();
    for (int g = 0; g < 2; g++) begin
      rx_n[g] = 0;
      done_n[g] = 0;
      fr_err[g] = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_act[0] || m_act[1]) && n < 3000) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 0, 32'(n < 3000), 32'd1);
    tick(2);
  endtask

  task automatic check_run(input int runs);
    for (int g = 0; g < 2; g++) begin
      chk("nbytes", g, 32'(rx_n[g]), 32'(runs * NB));
      for (int i = 0; i < runs * NB && i < rx_n[g] && i < 64; i++)
        chk("byte", g, 32'(rx_b[g][i]), 32'(mem[i % NB]));
      for (int r = 0; r < runs; r++)
        for (int i = 0; i < NB - 1; i++)
          if (r * NB + i + 1 < rx_n[g])
            chk("period", g, 32'(rx_t[g][r * NB + i + 1] - rx_t[g][r * NB + i]), 32'(EXP_BP[g]));
      chk("done_cnt", g, 32'(done_n[g]), 32'(runs));
      chk("done_lat", g, 32'(done_cyc[g] - acc_cyc[g]), 32'(EXP_TOT[g]));
      chk("framing", g, 32'(fr_err[g]), 32'd0);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < NB; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    for (int i = 0; i < NB; i++) mem[i] = 8'(i * 17);
    tick(3);
    chk_en = 1'b1;
    chk("rst_tx", 0, 32'(tx[0]), 32'd1);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_addr", 0, 32'(addr_rd[0]), 32'd0);
    chk("rst_ena", 0, 32'(ena_rd[0]), 32'd0);
    rst = 1'b1;
    tick(2);

    // 0x00..0x88 in order; conv_done dropped mid-readout
    clear_run();
    pulse_start(1'b1);
    conv_done = 1'b0;
    wait_idle();
    check_run(1);
    chk("byte3_lit", 0, 32'(rx_b[0][3]), 32'h33);

    // 0xA5 framing, each level held CPB cycles
    rand_mem();
    mem[0] = 8'hA5;
    clear_run();
    pulse_start(1'b1);
    wait_idle();
    check_run(1);
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 10; k++)
        for (int j = 0; j < int'(CPB); j++)
          chk("a5_frame", g, 32'(hist[g][g + 2 + int'(CPB) * k + j]), 32'(A5_FRAME[k]));

    // start without conv_done is ignored
    clear_run();
    pulse_start(1'b0);
    for (int i = 0; i < 100; i++) begin
      chk("nocd_busy", 0, 32'(busy[0]), 32'd0);
      chk("nocd_tx", 0, 32'(tx[0]), 32'd1);
      chk("nocd_ena", 0, 32'(ena_rd[0]), 32'd0);
      tick(1);
    end
    chk("nocd_bytes", 0, 32'(rx_n[0]), 32'd0);

    // start re-pulsed during byte 3 is ignored
    rand_mem();
    clear_run();
    pulse_start(1'b1);
    tick(3 * 42 + 10);
    pulse_start(1'b1);
    wait_idle();
    check_run(1);

    // reset during byte 5 DATA, then a full resend
    rand_mem();
    clear_run();
    pulse_start(1'b1);
    tick(5 * 42 + 15);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_tx", 0, 32'(tx[0]), 32'd1);
    chk("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("mid_rst_addr", 0, 32'(addr_rd[0]), 32'd0);
    rst = 1'b1;
    tick(1);
    clear_run();
    pulse_start(1'b1);
    wait_idle();
    check_run(1);

    // start and conv_done held high: back-to-back readouts
    rand_mem();
    clear_run();
    start = 1'b1;
    conv_done = 1'b1;
    tick(396);
    start = 1'b0;
    wait_idle();
    check_run(2);

    // randomized runs
    for (int r = 0; r < 3; r++) begin
      rand_mem();
      clear_run();
      start = 1'b1;
      conv_done = 1'b1;
      tick($urandom_range(1, 5));
      start = 1'b0;
      conv_done = 1'($urandom_range(0, 1));
      wait_idle();
      check_run(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
